video_vram_arbiter: RTL

Shares one VRAM memory port between the CPU read/write path (port A, fed by the video controller's write buffer) and the video line-fetch read path (port B). It sits between the video controller and the VRAM interface. The video side gets priority so scanline fetch meets raster deadlines. An optional fairness guard bounds how long CPU access can be starved.

---
 rtl/video_arb_pkg.sv | 20 ++
 rtl/video_vram_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/video_arb_pkg.sv
// Shared types and widths for the VRAM arbiter.
// Holds the FSM state, grant owner and bus width constants.
package video_arb_pkg;

  localparam int VRAM_ADDR_W = 32;
  localparam int VRAM_DATA_W = 32;
  localparam int VRAM_MASK_W = VRAM_DATA_W / 8;

  typedef enum bit [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  typedef enum bit {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

endpackage

// File: rtl/video_vram_arbiter.sv
// VRAM port arbiter: CPU path (A) vs video line fetch (B), B has priority.
// Ports: i_clock/i_reset (sync, active-high); i_pa_* / o_pa_* CPU side;
// i_pb_* / o_pb_* video read side; o_mem_* / i_mem_* downstream VRAM port.
// Define VIDEO_ARB_FAIR_EN to bound A starvation to VIDEO_BURST B grants.
module video_vram_arbiter
  import video_arb_pkg::*;
#(
  parameter int VIDEO_BURST = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_pa_request,
  input  logic                   i_pa_rw,
  input  logic [VRAM_ADDR_W-1:0] i_pa_address,
  input  logic [VRAM_DATA_W-1:0] i_pa_wdata,
  input  logic [VRAM_MASK_W-1:0] i_pa_wmask,
  output logic [VRAM_DATA_W-1:0] o_pa_rdata,
  output logic                   o_pa_ready,
  input  logic                   i_pb_request,
  input  logic [VRAM_ADDR_W-1:0] i_pb_address,
  output logic [VRAM_DATA_W-1:0] o_pb_rdata,
  output logic                   o_pb_ready,
  output logic                   o_mem_request,
  output logic                   o_mem_rw,
  output logic [VRAM_ADDR_W-1:0] o_mem_address,
  output logic [VRAM_DATA_W-1:0] o_mem_wdata,
  output logic [VRAM_MASK_W-1:0] o_mem_wmask,
  input  logic [VRAM_DATA_W-1:0] i_mem_rdata,
  input  logic                   i_mem_ready
);

  if (VIDEO_BURST < 1) begin : g_burst_chk
    $error("VIDEO_BURST must be at least 1");
  end

  state_t state;
  state_t state_next;
  owner_t owner;
  logic   grant;
  logic   force_a;

`ifdef VIDEO_ARB_FAIR_EN
  localparam int CNT_W = $clog2(VIDEO_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(VIDEO_BURST);

  logic [CNT_W-1:0] fair_cnt;

  // A wins a contested slot once B has had its full burst.
  assign force_a = (fair_cnt == CNT_MAX)
                 & i_pa_request & i_pb_request;
`else
  assign force_a = 1'b0;
`endif

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    owner      = OWNER_A;
    unique case (state)
      IDLE: begin
        if (i_pb_request && !force_a) begin
          grant      = 1'b1;
          owner      = OWNER_B;
          state_next = GRANT_B;
        end else if (i_pa_request) begin
          grant      = 1'b1;
          owner      = OWNER_A;
          state_next = GRANT_A;
        end
      end
      GRANT_A, GRANT_B: begin
        if (i_mem_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      o_mem_request <= 1'b0;
      o_mem_rw      <= 1'b0;
      o_mem_address <= '0;
      o_mem_wdata   <= '0;
      o_mem_wmask   <= '0;
`ifdef VIDEO_ARB_FAIR_EN
      fair_cnt      <= '0;
`endif
    end else begin
      state <= state_next;
      if (grant) begin
        o_mem_request <= 1'b1;
        if (owner == OWNER_B) begin
          o_mem_rw      <= 1'b0;
          o_mem_address <= i_pb_address;
          o_mem_wmask   <= '0;
        end else begin
          o_mem_rw      <= i_pa_rw;
          o_mem_address <= i_pa_address;
          o_mem_wdata   <= i_pa_wdata;
          o_mem_wmask   <= i_pa_wmask;
        end
      end else if (state != IDLE && i_mem_ready) begin
        o_mem_request <= 1'b0;
      end
`ifdef VIDEO_ARB_FAIR_EN
      // Count only B grants that actually made A wait.
      if (grant) begin
        if (owner == OWNER_A || !i_pa_request) begin
          fair_cnt <= '0;
        end else if (fair_cnt != CNT_MAX) begin
          fair_cnt <= fair_cnt + 1'b1;
        end
      end
`endif
    end
  end

  // Ready is suppressed under reset so an aborted beat never completes.
  assign o_pa_ready = (state == GRANT_A) & i_mem_ready & ~i_reset;
  assign o_pb_ready = (state == GRANT_B) & i_mem_ready & ~i_reset;

  assign o_pa_rdata = i_mem_rdata;
  assign o_pb_rdata = i_mem_rdata;

endmodule
